// File: rtl/pq_cmd_shim.sv
// pq_cmd_shim: buffers ENQ/DEQ/ENQ_DEQ commands and issues them one at a time to a priority queue.
// Define PQ_SHIM_STATS_EN to add saturating issue/drop counters (stat_enq, stat_deq, stat_drop).
module pq_cmd_shim #(
   parameter int KEY_WIDTH = 8,
   parameter int VAL_WIDTH = 8,
   parameter int CMD_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic [1:0]                     cmd_op,
   input  logic [KEY_WIDTH+VAL_WIDTH-1:0] cmd_kv,
   output logic                           res_valid,
   input  logic                           res_ready,
   output logic [KEY_WIDTH+VAL_WIDTH-1:0] res_kv,
   output logic                           err_drop,
`ifdef PQ_SHIM_STATS_EN
   output logic [15:0]                    stat_enq,
   output logic [15:0]                    stat_deq,
   output logic [15:0]                    stat_drop,
`endif
   output logic                           pq_enq,
   output logic                           pq_deq,
   output logic [KEY_WIDTH+VAL_WIDTH-1:0] pq_kvi,
   input  logic [KEY_WIDTH+VAL_WIDTH-1:0] pq_kvo,
   input  logic                           pq_busy,
   input  logic                           pq_full,
   input  logic                           pq_empty
);

   localparam int KVW = KEY_WIDTH + VAL_WIDTH;
   localparam int AW  = $clog2(CMD_DEPTH);

   localparam logic [1:0] OP_ENQ     = 2'b01;
   localparam logic [1:0] OP_DEQ     = 2'b10;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ISSUE  = 2'd1;
   localparam logic [1:0] ST_SETTLE = 2'd2;
   localparam logic [1:0] ST_WAIT   = 2'd3;

   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [1:0]     r_fifo_op [CMD_DEPTH];
   logic [KVW-1:0] r_fifo_kv [CMD_DEPTH];
   logic [AW:0]    r_wr_ptr;
   logic [AW:0]    r_rd_ptr;

   logic [1:0]     r_state;
   logic           r_pq_enq;
   logic           r_pq_deq;
   logic [KVW-1:0] r_pq_kvi;
   logic           r_res_valid;
   logic [KVW-1:0] r_res_kv;
   logic           r_err_drop;

   logic           w_fifo_empty;
   logic           w_fifo_full;
   logic           w_push;
   logic [1:0]     w_head_op;
   logic [KVW-1:0] w_head_kv;
   logic           w_res_blocked;
   logic           w_drop;
   logic           w_issue;
   logic           w_pass;
   logic           w_pop;
   logic           w_capture;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
   assign w_fifo_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push       = cmd_valid && !w_fifo_full && (cmd_op != 2'b00);
   assign w_head_op    = r_fifo_op[r_rd_ptr[AW-1:0]];
   assign w_head_kv    = r_fifo_kv[r_rd_ptr[AW-1:0]];
   assign w_res_blocked = r_res_valid && !res_ready;
   assign w_capture    = (r_state == ST_ISSUE) && r_pq_deq;

   // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      w_drop  = 1'b0;
      w_issue = 1'b0;
      w_pass  = 1'b0;
      if (r_state == ST_IDLE && !w_fifo_empty && !pq_busy) begin
         case (w_head_op)
            OP_ENQ: begin
               if (pq_full) w_drop  = 1'b1;
               else         w_issue = 1'b1;
            end
            OP_DEQ: begin
               if (pq_empty)            w_drop  = 1'b1;
               else if (!w_res_blocked) w_issue = 1'b1;
            end
            default: begin
               // ENQ_DEQ on an empty PQ returns its own pair without touching the PQ.
               if (!w_res_blocked) begin
                  if (pq_empty) w_pass  = 1'b1;
                  else          w_issue = 1'b1;
               end
            end
         endcase
      end
   end

   assign w_pop = w_drop || w_issue || w_pass;

   // NOTE: command storage is not reset; the pointers decide which entries are meaningful.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_op[r_wr_ptr[AW-1:0]] <= cmd_op;
         r_fifo_kv[r_wr_ptr[AW-1:0]] <= cmd_kv;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_pq_enq <= 1'b0;
         r_pq_deq <= 1'b0;
         r_pq_kvi <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_issue) begin
                  r_state  <= ST_ISSUE;
                  r_pq_enq <= w_head_op[0];
                  r_pq_deq <= w_head_op[1];
                  r_pq_kvi <= w_head_kv;
               end
            end
            ST_ISSUE: begin
               r_state  <= ST_SETTLE;
               r_pq_enq <= 1'b0;
               r_pq_deq <= 1'b0;
            end
            // The PQ may not have raised busy yet, so one cycle is spent ignoring it.
            ST_SETTLE: r_state <= ST_WAIT;
            default: begin
               if (!pq_busy) r_state <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res_valid <= 1'b0;
         r_res_kv    <= '0;
         r_err_drop  <= 1'b0;
      end else begin
         r_err_drop <= w_drop;
         if (w_capture) begin
            r_res_kv    <= pq_kvo;
            r_res_valid <= 1'b1;
         end else if (w_pass) begin
            r_res_kv    <= w_head_kv;
            r_res_valid <= 1'b1;
         end else if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
         end
      end
   end

`ifdef PQ_SHIM_STATS_EN
   logic [15:0] r_stat_enq;
   logic [15:0] r_stat_deq;
   logic [15:0] r_stat_drop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_enq  <= '0;
         r_stat_deq  <= '0;
         r_stat_drop <= '0;
      end else begin
         if (r_state == ST_ISSUE && r_pq_enq && r_stat_enq != 16'hFFFF)
            r_stat_enq <= r_stat_enq + 16'd1;
         if (r_state == ST_ISSUE && r_pq_deq && r_stat_deq != 16'hFFFF)
            r_stat_deq <= r_stat_deq + 16'd1;
         if (r_err_drop && r_stat_drop != 16'hFFFF)
            r_stat_drop <= r_stat_drop + 16'd1;
      end
   end

   assign stat_enq  = r_stat_enq;
   assign stat_deq  = r_stat_deq;
   assign stat_drop = r_stat_drop;
`endif

   assign cmd_ready = !w_fifo_full;
   assign res_valid = r_res_valid;
   assign res_kv    = r_res_kv;
   assign err_drop  = r_err_drop;
   assign pq_enq    = r_pq_enq;
   assign pq_deq    = r_pq_deq;
   assign pq_kvi    = r_pq_kvi;

endmodule

// File: tb/tb_pq_cmd_shim.sv
// tb_pq_cmd_shim: directed scenarios plus a randomized run checked against a queue-level model.
module tb_pq_cmd_shim;

   localparam int KVW    = 16;
   localparam int PQ_CAP = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           cmd_valid;
   logic           cmd_ready;
   logic [1:0]     cmd_op;
   logic [KVW-1:0] cmd_kv;
   logic           res_valid;
   logic           res_ready;
   logic [KVW-1:0] res_kv;
   logic           err_drop;
   logic           pq_enq;
   logic           pq_deq;
   logic [KVW-1:0] pq_kvi;
   logic [KVW-1:0] pq_kvo;
   logic           pq_busy;
   logic           pq_full;
   logic           pq_empty;
`ifdef PQ_SHIM_STATS_EN
   logic [15:0]    stat_enq;
   logic [15:0]    stat_deq;
   logic [15:0]    stat_drop;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   pq_cmd_shim #(.KEY_WIDTH(8), .VAL_WIDTH(8), .CMD_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_kv(cmd_kv),
      .res_valid(res_valid), .res_ready(res_ready), .res_kv(res_kv), .err_drop(err_drop),
`ifdef PQ_SHIM_STATS_EN
      .stat_enq(stat_enq), .stat_deq(stat_deq), .stat_drop(stat_drop),
`endif
      .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_kvi(pq_kvi), .pq_kvo(pq_kvo),
      .pq_busy(pq_busy), .pq_full(pq_full), .pq_empty(pq_empty)
   );

   always #5 clk = ~clk;

   // Environment PQ: min-key priority queue of capacity PQ_CAP with a random busy tail.
   logic [KVW-1:0] env_kv [PQ_CAP];
   int env_cnt;
   int env_min;
   int busy_cnt;
   int busy_max = 0;
   bit force_busy = 1'b0;

   always_comb begin
      env_min = 0;
      for (int i = 1; i < PQ_CAP; i++)
         if (i < env_cnt && env_kv[i][15:8] < env_kv[env_min][15:8]) env_min = i;
   end

   assign pq_kvo   = (env_cnt > 0) ? env_kv[env_min] : '0;
   assign pq_empty = (env_cnt == 0);
   assign pq_full  = (env_cnt == PQ_CAP);
   assign pq_busy  = force_busy || (busy_cnt != 0);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         env_cnt  <= 0;
         busy_cnt <= 0;
      end else begin
         if (pq_enq && pq_deq) begin
            if (env_cnt > 0) env_kv[env_min] <= pq_kvi;
         end else if (pq_enq) begin
            if (env_cnt < PQ_CAP) begin
               env_kv[env_cnt] <= pq_kvi;
               env_cnt <= env_cnt + 1;
            end
         end else if (pq_deq) begin
            if (env_cnt > 0) begin
               env_kv[env_min] <= env_kv[env_cnt-1];
               env_cnt <= env_cnt - 1;
            end
         end
         if (pq_enq || pq_deq) busy_cnt <= int'($urandom_range(busy_max, 0));
         else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
      end
   end

   // Observation of DUT activity, sampled mid-cycle.
   int cyc = 0;
   int mon_enq_n, mon_deq_n, mon_both_n, mon_drop_n;
   int last_strobe, min_gap;
   int enq_cyc[$];
   logic [KVW-1:0] enq_kv[$];
   logic [KVW-1:0] res_q[$];
   logic [1:0]     log_op[$];
   logic [KVW-1:0] log_kv[$];

   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (pq_enq) begin
            mon_enq_n++;
            enq_cyc.push_back(cyc);
            enq_kv.push_back(pq_kvi);
         end
         if (pq_deq) mon_deq_n++;
         if (pq_enq && pq_deq) mon_both_n++;
         if (pq_enq || pq_deq) begin
            if (last_strobe >= 0 && cyc - last_strobe < min_gap) min_gap = cyc - last_strobe;
            last_strobe = cyc;
         end
         if (err_drop) mon_drop_n++;
         if (res_valid && res_ready) res_q.push_back(res_kv);
         if (cmd_valid && cmd_ready && cmd_op != 2'b00) begin
            log_op.push_back(cmd_op);
            log_kv.push_back(cmd_kv);
         end
      end
   end

   task automatic mon_clear();
      mon_enq_n = 0; mon_deq_n = 0; mon_both_n = 0; mon_drop_n = 0;
      last_strobe = -1; min_gap = 1000;
      enq_cyc.delete(); enq_kv.delete(); res_q.delete();
      log_op.delete(); log_kv.delete();
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_kv = '0;
      res_ready = 1'b0; force_busy = 1'b0; busy_max = 0;
      step(); step();
      rst_n = 1'b1;
      step();
      mon_clear();
   endtask

   task automatic push(input logic [1:0] op, input logic [KVW-1:0] kv);
      cmd_valid = 1'b1; cmd_op = op; cmd_kv = kv;
      for (int i = 0; i < 50 && !cmd_ready; i++) step();
      step();
      cmd_valid = 1'b0; cmd_op = 2'b00;
   endtask

   task automatic wait_res();
      for (int i = 0; i < 40 && !res_valid; i++) step();
      n_cmp++;
      if (res_valid !== 1'b1) begin n_bad++; $display("FAIL res_timeout: res_valid=%b want 1", res_valid); end
   endtask

   task automatic take_res();
      res_ready = 1'b1; step(); res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_kv = '0; res_ready = 1'b0;
      step(); step();
      n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
      n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
      n_cmp++; if (res_kv !== 16'h0) begin n_bad++; $display("FAIL rst_res_kv: got %h want 0", res_kv); end
      n_cmp++; if (err_drop !== 1'b0) begin n_bad++; $display("FAIL rst_err_drop: got %b want 0", err_drop); end
      n_cmp++; if ({pq_enq, pq_deq} !== 2'b00) begin n_bad++; $display("FAIL rst_strobes: got %b want 00", {pq_enq, pq_deq}); end
      n_cmp++; if (pq_kvi !== 16'h0) begin n_bad++; $display("FAIL rst_pq_kvi: got %h want 0", pq_kvi); end
      rst_n = 1'b1;
      step();
      mon_clear();
   endtask

   task automatic test_enq_burst();
      logic [KVW-1:0] kvs [3];
      logic rdy [3];
      kvs[0] = {8'd20, 8'd1}; kvs[1] = {8'd80, 8'd2}; kvs[2] = {8'd30, 8'd3};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cmd_valid = 1'b1; cmd_op = 2'b01; cmd_kv = kvs[i]; rdy[i] = cmd_ready;
         step();
      end
      cmd_valid = 1'b0; cmd_op = 2'b00;
      for (int i = 0; i < 40 && enq_cyc.size() < 3; i++) step();
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (rdy[i] !== 1'b1) begin n_bad++; $display("FAIL burst_ready%0d: got %b want 1", i, rdy[i]); end
      end
      n_cmp++;
      if (enq_cyc.size() != 3) begin n_bad++; $display("FAIL burst_pulses: got %0d want 3", enq_cyc.size()); end
      else begin
         for (int i = 0; i < 3; i++) begin
            n_cmp++; if (enq_kv[i] !== kvs[i]) begin n_bad++; $display("FAIL burst_kvi%0d: got %h want %h", i, enq_kv[i], kvs[i]); end
         end
         for (int i = 1; i < 3; i++) begin
            n_cmp++; if (enq_cyc[i] - enq_cyc[i-1] < 4) begin n_bad++; $display("FAIL burst_gap%0d: got %0d want >=4", i, enq_cyc[i] - enq_cyc[i-1]); end
         end
      end
   endtask

   // Runs on the PQ left by test_enq_burst: {20,1},{80,2},{30,3}.
   task automatic test_deq();
      mon_clear();
      push(2'b10, '0);
      wait_res();
      n_cmp++; if (res_kv !== {8'd20, 8'd1}) begin n_bad++; $display("FAIL deq_kv: got %h want %h", res_kv, {8'd20, 8'd1}); end
      step(); step(); step();
      n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL deq_hold: res_valid=%b want 1", res_valid); end
      take_res();
      n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL deq_taken: res_valid=%b want 0", res_valid); end
      n_cmp++; if (mon_deq_n != 1) begin n_bad++; $display("FAIL deq_pulses: got %0d want 1", mon_deq_n); end
   endtask

   task automatic test_deq_empty();
      do_reset();
      push(2'b10, '0);
      for (int i = 0; i < 10; i++) step();
      n_cmp++; if (mon_drop_n != 1) begin n_bad++; $display("FAIL drop_cycles: got %0d want 1", mon_drop_n); end
      n_cmp++; if (mon_deq_n != 0) begin n_bad++; $display("FAIL drop_no_deq: got %0d want 0", mon_deq_n); end
      n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL drop_res_valid: got %b want 0", res_valid); end
   endtask

   task automatic test_enq_deq();
      do_reset();
      push(2'b01, {8'd20, 8'd1});
      for (int i = 0; i < 8; i++) step();
      push(2'b11, {8'd90, 8'd8});
      wait_res();
      n_cmp++; if (res_kv !== {8'd20, 8'd1}) begin n_bad++; $display("FAIL enqdeq_kv: got %h want %h", res_kv, {8'd20, 8'd1}); end
      n_cmp++; if (mon_both_n != 1) begin n_bad++; $display("FAIL enqdeq_both: got %0d want 1", mon_both_n); end
      take_res();
      push(2'b10, '0);
      wait_res();
      n_cmp++; if (res_kv !== {8'd90, 8'd8}) begin n_bad++; $display("FAIL enqdeq_after: got %h want %h", res_kv, {8'd90, 8'd8}); end
      take_res();
   endtask

   task automatic test_result_stall();
      do_reset();
      push(2'b01, {8'd20, 8'd1});
      push(2'b01, {8'd30, 8'd3});
      for (int i = 0; i < 12; i++) step();
      mon_clear();
      push(2'b10, '0);
      push(2'b10, '0);
      for (int i = 0; i < 20; i++) step();
      n_cmp++; if (mon_deq_n != 1) begin n_bad++; $display("FAIL stall_deq1: got %0d want 1", mon_deq_n); end
      n_cmp++; if (res_kv !== {8'd20, 8'd1}) begin n_bad++; $display("FAIL stall_kv1: got %h want %h", res_kv, {8'd20, 8'd1}); end
      take_res();
      for (int i = 0; i < 12; i++) step();
      n_cmp++; if (mon_deq_n != 2) begin n_bad++; $display("FAIL stall_deq2: got %0d want 2", mon_deq_n); end
      n_cmp++; if (res_kv !== {8'd30, 8'd3} || res_valid !== 1'b1) begin
         n_bad++; $display("FAIL stall_kv2: got %h/%b want %h/1", res_kv, res_valid, {8'd30, 8'd3});
      end
      take_res();
   endtask

   task automatic test_busy_stuck_and_reset();
      do_reset();
      force_busy = 1'b1;
      cmd_valid = 1'b1; cmd_op = 2'b01;
      for (int i = 0; i < 6; i++) begin
         cmd_kv = {8'(40 + i), 8'(i)};
         step();
      end
      n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL stuck_ready: got %b want 0", cmd_ready); end
      n_cmp++; if (mon_enq_n + mon_deq_n != 0) begin n_bad++; $display("FAIL stuck_strobes: got %0d want 0", mon_enq_n + mon_deq_n); end
      force_busy = 1'b0;
      for (int i = 0; i < 10 && mon_enq_n == 0; i++) step();
      force_busy = 1'b1;
      cmd_valid = 1'b0; cmd_op = 2'b00;
      step(); step(); step();
      rst_n = 1'b0;
      step();
      n_cmp++; if ({pq_enq, pq_deq} !== 2'b00) begin n_bad++; $display("FAIL midrst_strobes: got %b want 00", {pq_enq, pq_deq}); end
      n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_res_valid: got %b want 0", res_valid); end
      n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_cmd_ready: got %b want 1", cmd_ready); end
      force_busy = 1'b0;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_random();
      logic [KVW-1:0] m_pq[$];
      logic [KVW-1:0] exp_res[$];
      int exp_drop, exp_enq, exp_deq, mi;
      do_reset();
      busy_max = 3;
      for (int k = 0; k < 250; k++) begin
         cmd_valid = ($urandom_range(3) != 0);
         cmd_op    = 2'($urandom_range(3));
         cmd_kv    = {8'((k * 37) & 255), 8'($urandom_range(255))};
         res_ready = ($urandom_range(1) == 1);
         step();
      end
      cmd_valid = 1'b0; cmd_op = 2'b00; res_ready = 1'b1;
      for (int i = 0; i < 200; i++) step();
      res_ready = 1'b0;

      // Command-level reference: outcome of each accepted command in order against a min-key queue.
      exp_drop = 0; exp_enq = 0; exp_deq = 0;
      for (int c = 0; c < log_op.size(); c++) begin
         mi = 0;
         for (int j = 1; j < m_pq.size(); j++) if (m_pq[j][15:8] < m_pq[mi][15:8]) mi = j;
         case (log_op[c])
            2'b01: if (m_pq.size() == PQ_CAP) exp_drop++;
                   else begin m_pq.push_back(log_kv[c]); exp_enq++; end
            2'b10: if (m_pq.size() == 0) exp_drop++;
                   else begin exp_res.push_back(m_pq[mi]); m_pq.delete(mi); exp_deq++; end
            default: if (m_pq.size() == 0) exp_res.push_back(log_kv[c]);
                     else begin exp_res.push_back(m_pq[mi]); m_pq[mi] = log_kv[c]; exp_enq++; exp_deq++; end
         endcase
      end

      n_cmp++; if (res_q.size() != exp_res.size()) begin n_bad++; $display("FAIL rnd_res_count: got %0d want %0d", res_q.size(), exp_res.size()); end
      for (int i = 0; i < res_q.size() && i < exp_res.size(); i++) begin
         n_cmp++; if (res_q[i] !== exp_res[i]) begin n_bad++; $display("FAIL rnd_res%0d: got %h want %h", i, res_q[i], exp_res[i]); end
      end
      n_cmp++; if (mon_drop_n != exp_drop) begin n_bad++; $display("FAIL rnd_drops: got %0d want %0d", mon_drop_n, exp_drop); end
      n_cmp++; if (mon_enq_n != exp_enq) begin n_bad++; $display("FAIL rnd_enq: got %0d want %0d", mon_enq_n, exp_enq); end
      n_cmp++; if (mon_deq_n != exp_deq) begin n_bad++; $display("FAIL rnd_deq: got %0d want %0d", mon_deq_n, exp_deq); end
      n_cmp++; if (min_gap < 4) begin n_bad++; $display("FAIL rnd_issue_gap: got %0d want >=4", min_gap); end
   endtask

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_kv = '0; res_ready = 1'b0;
      mon_clear();
      test_reset();
      test_enq_burst();
      test_deq();
      test_deq_empty();
      test_enq_deq();
      test_result_stall();
      test_busy_stuck_and_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
